// File: rtl/hazard_unit_n_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_unit_n_if : ID/EX/forwarding bundle of the multi-issue hazard unit.
// Rev 1.0
// ---------------------------------------------------------------------------
interface hazard_unit_n_if #(
  parameter int LANES = 2,
  parameter int REG_W = 5
);
  localparam int FSEL_W = $clog2(3 * LANES + 1);

  logic                    flush;
  logic                    id_valid;
  logic                    id_ready;
  logic [LANES*REG_W-1:0]  id_rs1;
  logic [LANES*REG_W-1:0]  id_rs2;
  logic [LANES*REG_W-1:0]  id_rd;
  logic [LANES-1:0]        id_wb;
  logic [LANES-1:0]        id_load;
  logic [LANES-1:0]        ex_lane_valid;
  logic [LANES-1:0]        ex_wb;
  logic [LANES-1:0]        ex_load;
  logic [LANES*REG_W-1:0]  ex_rd;
  logic [LANES*REG_W-1:0]  exmem_rd;
  logic [LANES*REG_W-1:0]  memwb_rd;
  logic [LANES-1:0]        exmem_wb;
  logic [LANES-1:0]        memwb_wb;
  logic [LANES*FSEL_W-1:0] fwd_a;
  logic [LANES*FSEL_W-1:0] fwd_b;
  logic [15:0]             stall_cnt;

  modport master (
    output flush, id_valid, id_rs1, id_rs2, id_rd, id_wb, id_load,
           exmem_rd, memwb_rd, exmem_wb, memwb_wb,
    input  id_ready, ex_lane_valid, ex_wb, ex_load, ex_rd, fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  flush, id_valid, id_rs1, id_rs2, id_rd, id_wb, id_load,
           exmem_rd, memwb_rd, exmem_wb, memwb_wb,
    output id_ready, ex_lane_valid, ex_wb, ex_load, ex_rd, fwd_a, fwd_b, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/hazard_unit_n.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_unit_n : in-order multi-issue load-use stall, partial issue and
// operand forwarding select.  Rev 1.0
// ---------------------------------------------------------------------------
module hazard_unit_n #(
  parameter int LANES = 2,
  parameter int REG_W = 5
) (
  input logic            clk,
  input logic            reset_n,
  hazard_unit_n_if.slave bus
);
  localparam int FSEL_W = $clog2(3 * LANES + 1);

  logic [LANES-1:0]       issued_q, issued_d;
  logic [LANES-1:0]       ex_valid_q, ex_valid_d;
  logic [LANES-1:0]       ex_wb_q, ex_wb_d;
  logic [LANES-1:0]       ex_load_q, ex_load_d;
  logic [LANES*REG_W-1:0] ex_rd_q, ex_rd_d;
  logic [LANES*REG_W-1:0] ex_rs1_q, ex_rs1_d;
  logic [LANES*REG_W-1:0] ex_rs2_q, ex_rs2_d;
  logic [15:0]            stall_cnt_q, stall_cnt_d;

  logic [LANES-1:0]        unissued;
  logic [LANES-1:0]        hazard;
  logic [LANES-1:0]        issue;
  logic                    ready;
  logic [LANES*FSEL_W-1:0] fwd_a, fwd_b;

  function automatic logic [REG_W-1:0] lane_reg(input logic [LANES*REG_W-1:0] v,
                                                input int idx);
    return v[idx*REG_W +: REG_W];
  endfunction

  // x0 is hardwired, so it never creates a dependency
  function automatic logic reg_match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  assign unissued = ~issued_q;

  always_comb begin : hazard_detect
    logic blocked;
    hazard  = '0;
    issue   = '0;
    blocked = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < LANES; j++) begin
        if (ex_valid_q[j] && ex_load_q[j] &&
            (reg_match(lane_reg(bus.id_rs1, i), lane_reg(ex_rd_q, j)) ||
             reg_match(lane_reg(bus.id_rs2, i), lane_reg(ex_rd_q, j))))
          hazard[i] = 1'b1;
      end
      for (int j = 0; j < i; j++) begin
        if (unissued[j] && bus.id_load[j] &&
            (reg_match(lane_reg(bus.id_rs1, i), lane_reg(bus.id_rd, j)) ||
             reg_match(lane_reg(bus.id_rs2, i), lane_reg(bus.id_rd, j))))
          hazard[i] = 1'b1;
      end
      hazard[i] = hazard[i] & unissued[i];
    end
    // Issue stays in order: everything past the oldest hazarded lane waits
    for (int i = 0; i < LANES; i++) begin
      if (hazard[i])
        blocked = 1'b1;
      if (bus.id_valid && unissued[i] && !blocked)
        issue[i] = 1'b1;
    end
    ready = reset_n & bus.id_valid & ~bus.flush & (issue == unissued);
  end

  always_comb begin
    issued_d    = issued_q;
    ex_valid_d  = '0;
    ex_wb_d     = '0;
    ex_load_d   = '0;
    ex_rd_d     = '0;
    ex_rs1_d    = '0;
    ex_rs2_d    = '0;
    stall_cnt_d = stall_cnt_q;
    if (bus.flush) begin
      issued_d = '0;
    end else begin
      ex_valid_d = issue;
      ex_wb_d    = bus.id_wb & issue;
      ex_load_d  = bus.id_load & issue;
      for (int i = 0; i < LANES; i++) begin
        if (issue[i]) begin
          ex_rd_d[i*REG_W +: REG_W]  = lane_reg(bus.id_rd, i);
          ex_rs1_d[i*REG_W +: REG_W] = lane_reg(bus.id_rs1, i);
          ex_rs2_d[i*REG_W +: REG_W] = lane_reg(bus.id_rs2, i);
        end
      end
      issued_d = ready ? '0 : (issued_q | issue);
      if (bus.id_valid && (issue == '0) && (stall_cnt_q != 16'hFFFF))
        stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      issued_q    <= '0;
      ex_valid_q  <= '0;
      ex_wb_q     <= '0;
      ex_load_q   <= '0;
      ex_rd_q     <= '0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      issued_q    <= issued_d;
      ex_valid_q  <= ex_valid_d;
      ex_wb_q     <= ex_wb_d;
      ex_load_q   <= ex_load_d;
      ex_rd_q     <= ex_rd_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Lowest priority source is applied first so later, closer producers override
  always_comb begin : fwd_select
    logic [FSEL_W-1:0] sel_a, sel_b;
    fwd_a = '0;
    fwd_b = '0;
    for (int i = 0; i < LANES; i++) begin
      sel_a = '0;
      sel_b = '0;
      for (int j = 0; j < LANES; j++) begin
        if (bus.memwb_wb[j]) begin
          if (reg_match(lane_reg(ex_rs1_q, i), lane_reg(bus.memwb_rd, j)))
            sel_a = FSEL_W'(1 + 2 * LANES + j);
          if (reg_match(lane_reg(ex_rs2_q, i), lane_reg(bus.memwb_rd, j)))
            sel_b = FSEL_W'(1 + 2 * LANES + j);
        end
      end
      for (int j = 0; j < LANES; j++) begin
        if (bus.exmem_wb[j]) begin
          if (reg_match(lane_reg(ex_rs1_q, i), lane_reg(bus.exmem_rd, j)))
            sel_a = FSEL_W'(1 + LANES + j);
          if (reg_match(lane_reg(ex_rs2_q, i), lane_reg(bus.exmem_rd, j)))
            sel_b = FSEL_W'(1 + LANES + j);
        end
      end
      for (int j = 0; j < i; j++) begin
        if (ex_valid_q[j] && ex_wb_q[j]) begin
          if (reg_match(lane_reg(ex_rs1_q, i), lane_reg(ex_rd_q, j)))
            sel_a = FSEL_W'(1 + j);
          if (reg_match(lane_reg(ex_rs2_q, i), lane_reg(ex_rd_q, j)))
            sel_b = FSEL_W'(1 + j);
        end
      end
      if (ex_valid_q[i]) begin
        fwd_a[i*FSEL_W +: FSEL_W] = sel_a;
        fwd_b[i*FSEL_W +: FSEL_W] = sel_b;
      end
    end
  end

  assign bus.id_ready      = ready;
  assign bus.ex_lane_valid = ex_valid_q;
  assign bus.ex_wb         = ex_wb_q;
  assign bus.ex_load       = ex_load_q;
  assign bus.ex_rd         = ex_rd_q;
  assign bus.fwd_a         = fwd_a;
  assign bus.fwd_b         = fwd_b;
  assign bus.stall_cnt     = stall_cnt_q;
endmodule
`default_nettype wire

// File: doc/hazard_unit_n.md
HAZARD_UNIT_N -- requirements
Module: hazard_unit_n

Interface
REQ-001 Parameter LANES, default 2, issue width (legal 2..4).
REQ-002 Parameter REG_W, default 5, register-address width.
REQ-003 Derived FSEL_W = $clog2(3*LANES+1), forward-select width per operand.
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 flush  in  1  discard EX bundle and partially issued ID bundle.
REQ-007 id_valid  in  1  ID bundle present.
REQ-008 id_ready  out  1  ID bundle fully issued this cycle (combinational).
REQ-009 id_rs1, id_rs2, id_rd  in  LANES*REG_W each  lane i at [i*REG_W +: REG_W]; lane 0 oldest.
REQ-010 id_wb, id_load  in  LANES each  lane writes register / lane is a load.
REQ-011 ex_lane_valid, ex_wb, ex_load  out  LANES each  registered EX bundle.
REQ-012 ex_rd  out  LANES*REG_W  registered EX destinations.
REQ-013 exmem_rd, memwb_rd  in  LANES*REG_W each; exmem_wb, memwb_wb  in  LANES each  downstream writers.
REQ-014 fwd_a, fwd_b  out  LANES*FSEL_W each  forward select for rs1/rs2 of EX lanes (combinational).
REQ-015 stall_cnt  out  16  saturating count of full-stall cycles.

Function
REQ-016 Block SHALL hold internal issued[LANES] mask and registered EX copies of rs1/rs2/rd/wb/load per lane.
REQ-017 Unissued ID lane i SHALL be hazarded if its rs1 or rs2 (nonzero) equals ex_rd[j] of any lane j with ex_lane_valid & ex_load, or equals id_rd[j] of any unissued lane j<i with id_load.
REQ-018 Register 0 SHALL never match in any hazard or forward comparison.
REQ-019 Issue set SHALL be all unissued lanes with index below the lowest-index hazarded unissued lane (all unissued lanes if none hazarded); empty when id_valid=0.
REQ-020 id_ready SHALL be 1 iff id_valid=1, flush=0, and issue set equals all unissued lanes.
REQ-021 On each edge: ex_lane_valid <= issue set; ex_rd/ex_wb/ex_load <= ID fields for issued lanes, 0 otherwise; latency ID->EX exactly 1 cycle.
REQ-022 issued SHALL clear when id_ready=1, else OR in issue set (partial issue); ID inputs held stable by upstream while id_ready=0.
REQ-023 Flush SHALL have priority: next ex_lane_valid=0, issued=0, id_ready=0 that cycle.
REQ-024 stall_cnt SHALL increment when id_valid=1, flush=0, issue set empty; hold at 16'hFFFF.
REQ-025 fwd for valid EX lane i, per operand, priority: (1) largest j<i with ex_lane_valid&ex_wb&ex_rd match -> 1+j; (2) largest j with exmem_wb match -> 1+LANES+j; (3) largest j with memwb_wb match -> 1+2*LANES+j; (4) else 0.
REQ-026 fwd for invalid EX lane SHALL be 0.

Reset
REQ-027 While reset_n=0 at an edge: ex_lane_valid, ex_rd, ex_wb, ex_load, issued, stall_cnt <= 0.
REQ-028 While reset_n=0, id_ready SHALL be 0; fwd outputs 0 after reset edge.
REQ-029 Reset mid-partial-issue SHALL discard the bundle; first cycle after reset treats all lanes unissued.

Verification (LANES=2)
REQ-030 No hazard: lane0 add x5, lane1 add x6<-x5 -> id_ready=1, next cycle ex_lane_valid=2'b11, fwd_a lane1=1.
REQ-031 Intra load-use: lane0 load x7, lane1 rs1=x7 -> cycle1 issue 2'b01, id_ready=0; cycle2 issue empty, stall_cnt=1; cycle3 issue 2'b10, id_ready=1.
REQ-032 EX load-use: EX lane1 load x9, ID lane0 rs2=x9 -> issue empty, ex_lane_valid=0 next, stall_cnt+1.
REQ-033 Priority: EX lane1 rs1=x3, exmem lane0 and memwb lane1 both write x3 -> fwd_a lane1=3; exmem_wb removed -> 6.
REQ-034 x0: all rd/rs=0 with loads -> no stall, all fwd 0.
REQ-035 Flush during partial issue (issued=01) -> next ex_lane_valid=0, issued=0; saturation: 65536 stall cycles -> stall_cnt=16'hFFFF held.
